// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Frames are loaded through valid/ready into a pending buffer and committed only at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] load_data_i,
    input  logic [NUM_DIGITS-1:0]   load_dp_i,
    input  logic                    lz_blank_en_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [2:0]              digit_idx_o
);

    // state      | meaning
    // PEND_EMPTY | no frame waiting; load_ready high, next valid is captured
    // PEND_FULL  | frame waiting; copied to the active frame at the next frame boundary

    localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   DEAD_L     = PW'(DEAD_CYCLES);
    localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        PEND_EMPTY,
        PEND_FULL
    } pend_state_t;

    pend_state_t pend_state_q, pend_state_d;

    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [2:0]              didx_q;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    zero_run;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (presc_q == PRESC_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        pend_state_d = pend_state_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        load_ready_o = 1'b0;
        case (pend_state_q)
            PEND_EMPTY: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    pend_data_d  = load_data_i;
                    pend_dp_d    = load_dp_i;
                    pend_state_d = PEND_FULL;
                end
            end
            PEND_FULL: begin
                if (frame_end) begin
                    act_data_d   = pend_data_q;
                    act_dp_d     = pend_dp_q;
                    pend_state_d = PEND_EMPTY;
                end
            end
            default: pend_state_d = PEND_EMPTY;
        endcase
    end

    // Walk from the most significant digit down so zero_run tells whether
    // every digit above and including i is zero.
    always_comb begin
        cur_nib  = 4'hF;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data_q[4*i +: 4] == 4'd0);
            if (idx_q == 3'(i)) begin
                cur_nib = act_data_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
                cur_lz  = lz_blank_en_i && (i != 0) && zero_run;
            end
        end
        seg_d = cur_lz ? 7'b1111111 : bcd_to_seg(cur_nib);
        dp_d  = ~cur_dp;
        an_d  = (presc_q < DEAD_L) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            pend_state_q <= PEND_EMPTY;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            act_data_q   <= '1;
            act_dp_q     <= '0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            didx_q       <= 3'd0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_state_q <= pend_state_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            didx_q       <= idx_q;
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign digit_idx_o = didx_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: table vectors, hand sequences and random traffic
// checked every cycle against a time-indexed reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int D  = 1;
    localparam int FR = R * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_dp = 4'h0;
    logic        load_ready_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [2:0]  digit_idx_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data),
        .load_dp_i    (load_dp),
        .lz_blank_en_i(lz),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .digit_idx_o  (digit_idx_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the scan position is a pure function of cycles since reset.
    logic [6:0]  seg_tab [16];
    bit          m_init = 0;
    int          m_t, m_last_p, m_last_d, mp, md;
    logic [15:0] m_act, m_pdata;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pend;
    logic [3:0]  e_an, mnib;
    logic [6:0]  e_seg;
    logic        e_dp, e_ready;
    logic [2:0]  e_idx;

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_t = 0; m_pend = 0; m_act = 16'hFFFF; m_adp = 4'h0;
            m_pdata = 16'h0; m_pdp = 4'h0; m_last_p = 0; m_last_d = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 3'd0; e_ready = 1'b1;
        end else if (m_init) begin
            mp = m_t % R;
            md = (m_t / R) % N;
            e_an = (mp < D) ? 4'hF : ~(4'b0001 << md);
            mnib = m_act[4*md +: 4];
            if (lz && md >= 1 && (m_act >> (4*md)) == 16'd0) e_seg = 7'h7F;
            else e_seg = seg_tab[mnib];
            e_dp = ~m_adp[md];
            e_idx = 3'(md);
            if (m_pend && (m_t % FR) == FR - 1) begin
                m_act = m_pdata; m_adp = m_pdp; m_pend = 0;
            end else if (load_valid && !m_pend) begin
                m_pdata = load_data; m_pdp = load_dp; m_pend = 1;
            end
            e_ready = !m_pend;
            m_last_p = mp;
            m_last_d = md;
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_an", an_o, e_an);
            chk("model_seg", seg_o, e_seg);
            chk("model_dp", dp_o, e_dp);
            chk("model_idx", digit_idx_o, e_idx);
            chk("model_ready", load_ready_o, e_ready);
        end
    end

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       dp;
        logic             lz;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpo;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_ready(input string nm);
        for (int n = 0; n < 3*FR && !load_ready_o; n++) @(negedge clk);
        if (!load_ready_o) chk(nm, load_ready_o, 1);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p);
        load_data = d; load_dp = p; load_valid = 1'b1;
        for (int n = 0; n < 3*FR && !load_ready_o; n++) @(negedge clk);
        if (!load_ready_o) begin
            chk("offer_timeout", load_ready_o, 1);
            load_valid = 1'b0;
        end else begin
            @(negedge clk);
            load_valid = 1'b0;
            chk("ready_drop", load_ready_o, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [3:0] exp_an;
    bit         will_acc;
    int         k;

    initial begin
        vecs[0] = '{data:16'h1234, dp:4'b0100, lz:1'b0,
                    seg:{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, dpo:4'b1011};
        vecs[1] = '{data:16'h0007, dp:4'b0000, lz:1'b1,
                    seg:{7'h7F, 7'h7F, 7'h7F, 7'b0001111}, dpo:4'b1111};
        vecs[2] = '{data:16'h0000, dp:4'b0000, lz:1'b1,
                    seg:{7'h7F, 7'h7F, 7'h7F, 7'b0000001}, dpo:4'b1111};
        vecs[3] = '{data:16'h0000, dp:4'b0000, lz:1'b0,
                    seg:{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, dpo:4'b1111};
        vecs[4] = '{data:16'hA9FB, dp:4'b0000, lz:1'b0,
                    seg:{7'h7F, 7'b0000100, 7'h7F, 7'h7F}, dpo:4'b1111};
        vecs[5] = '{data:16'h0100, dp:4'b1001, lz:1'b1,
                    seg:{7'h7F, 7'b1001111, 7'b0000001, 7'b0000001}, dpo:4'b0110};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", an_o, 4'hF);
        chk("rst_seg", seg_o, 7'h7F);
        chk("rst_dp", dp_o, 1'b1);
        chk("rst_ready", load_ready_o, 1'b1);
        chk("rst_idx", digit_idx_o, 3'd0);
        reset = 1'b0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            chk("blank_frame", seg_o, 7'h7F);
        end

        for (int v = 0; v < 6; v++) begin
            lz = vecs[v].lz;
            wait_ready($sformatf("vec%0d_ready", v));
            @(negedge clk);
            offer(vecs[v].data, vecs[v].dp);
            repeat (2*FR) @(negedge clk);
            for (int i = 0; i < FR; i++) begin
                @(negedge clk);
                if (m_last_p >= D) begin
                    exp_an = ~(4'b0001 << m_last_d);
                    chk($sformatf("vec%0d_seg", v), seg_o, vecs[v].seg[m_last_d]);
                    chk($sformatf("vec%0d_dp", v), dp_o, vecs[v].dpo[m_last_d]);
                    chk($sformatf("vec%0d_an", v), an_o, exp_an);
                end else begin
                    chk($sformatf("vec%0d_dead", v), an_o, 4'hF);
                end
            end
        end

        // Back-to-back: second frame held valid while the first is pending.
        lz = 1'b0;
        offer(16'h1111, 4'h0);
        load_data = 16'h2222; load_dp = 4'h0; load_valid = 1'b1;
        for (k = 0; k < 2*FR && !load_ready_o; k++) @(negedge clk);
        chk("b2b_ready_rise", load_ready_o, 1);
        chk("b2b_rise_idx", digit_idx_o, 3'd3);
        chk("b2b_rise_an", an_o, 4'b0111);
        @(negedge clk);
        load_valid = 1'b0;
        chk("b2b_accept", load_ready_o, 0);
        chk("b2b_first", seg_o, 7'b1001111);
        repeat (FR) @(negedge clk);
        chk("b2b_second", seg_o, 7'b0010010);

        // Reset while a frame is pending: it must never show up.
        wait_ready("rst2_ready_wait");
        for (k = 0; k < FR && (m_t % FR) != 2; k++) @(negedge clk);
        offer(16'h8888, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_an", an_o, 4'hF);
        chk("rst2_seg", seg_o, 7'h7F);
        chk("rst2_dp", dp_o, 1'b1);
        chk("rst2_idx", digit_idx_o, 3'd0);
        chk("rst2_ready", load_ready_o, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 3*FR; i++) begin
            @(negedge clk);
            chk("stale_frame", seg_o, 7'h7F);
        end

        // Random traffic; data held stable until accepted.
        will_acc = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (load_valid && will_acc) load_valid = 1'b0;
            if (!load_valid && $urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++)
                    load_data[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                load_dp = 4'($urandom_range(0, 15));
                load_valid = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) lz = ~lz;
            will_acc = load_valid && load_ready_o;
        end
        load_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
